decode_frame_ctrl: RTL and testbench
====================================

# decode_frame_ctrl

Parametrised frame controller for the decoder core, successor to the fixed-length load controller. Latches mode and code on `i_core_set`, then runs one frame through three phases. Load streams per-code beat counts with a valid/ready stall handshake, driving the syndrome, LLR-memory and error-bit-saver strobes. Decode sequences iterations with early-stop and max-iteration termination. Done reports frame completion.

## Interface
- `LEN0`, default 8: beats per frame for code index 0.
- `LEN1`, default 32: beats per frame for code index 1.
- `LEN2`, default 128: beats per frame for code index 2.
- `CNT_W`, default 8: beat counter width; must satisfy 2^CNT_W ≥ max(LEN0,LEN1,LEN2).
- `MAX_ITER`, default 15: iteration limit; must be ≥1.
- `ITER_W`, default 4: iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- `i_clk` in 1: clock, all state updates on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_core_set` in 1: start a new frame; aborts any frame in progress.
- `i_core_mode` in 1: 1 = soft (LLR store + decode), 0 = hard (syndrome only).
- `i_core_code` in 2: code select; mapped to index 0,0,1,2 for values 0,1,2,3.
- `i_core_valid` in 1: input beat present.
- `o_core_ready` out 1: controller accepts a beat.
- `o_mode` out 1: latched mode.
- `o_code` out 2: latched code index.
- `o_beat_idx` out CNT_W: index of the current load beat.
- `o_syndrome_clear_and_wen` out 1: first accepted beat.
- `o_syndrome_wen` out 1: any accepted beat.
- `o_llr_mem_wen` out 1: accepted beat and mode=1.
- `o_error_bit_saver_clear` out 1: one-cycle clear at frame start.
- `o_iter_start` out 1: pulse launching one decode iteration.
- `i_iter_done` in 1: decode iteration finished.
- `o_iter_cnt` out ITER_W: completed iterations this frame.
- `i_early_stop_pulse` in 1: syndrome became zero.
- `o_early_stop` out 1: sticky early-stop flag.
- `o_max_iter_hit` out 1: sticky iteration-limit flag.
- `o_busy` out 1: frame in progress.
- `o_done` out 1: one-cycle frame-complete pulse.

## Operation
- FSM states: IDLE, CLEAR, LOAD, DECODE, DONE.
- Reset:
  - State → IDLE.
  - mode, code, beat count and iteration count → 0.
  - Every output → 0.
- `i_core_set` in any state (including mid-frame):
  - Latches mode and code.
  - Clears the beat count, iteration count, `o_early_stop` and `o_max_iter_hit`.
  - State → CLEAR next cycle.
  - `i_core_set` has priority over every other event in the same cycle.
- CLEAR (one cycle):
  - `o_error_bit_saver_clear`=1, `o_busy`=1.
  - Next state: LOAD.
- LOAD:
  - `o_core_ready`=1; a beat is accepted when `i_core_valid`=1.
  - Strobes are combinational and asserted in the accept cycle:
    - `o_syndrome_wen`=1.
    - `o_syndrome_clear_and_wen`=1 iff beat index 0.
    - `o_llr_mem_wen`=`o_mode`.
  - With no valid, the controller holds and no strobes are asserted.
  - The beat index increments on each accept.
  - Accepting beat LEN(code)−1 exits LOAD:
    - To DONE if mode=0 or `o_early_stop`=1.
    - Otherwise to DECODE.
- DECODE:
  - `o_iter_start` pulses on the first DECODE cycle.
  - On each `i_iter_done`, `o_iter_cnt` increments.
  - `o_iter_start` pulses again on the next cycle unless the frame terminates.
- Termination in DECODE, resolved in the same cycle:
  - `i_early_stop_pulse` → DONE.
  - Otherwise, `i_iter_done` with `o_iter_cnt`=MAX_ITER−1 → DONE and `o_max_iter_hit`=1.
  - If both arrive in the same cycle, early stop wins and `o_max_iter_hit` stays 0.
- `i_early_stop_pulse` sets `o_early_stop` in CLEAR, LOAD or DECODE. It is ignored in IDLE and DONE.
- DONE (one cycle):
  - `o_done`=1, `o_busy`=0.
  - Next state: IDLE.
- Flags and counters hold through IDLE until the next `i_core_set`.
- `o_busy`=1 in CLEAR, LOAD and DECODE.

## Timing
- `i_core_set` at cycle t:
  - `o_error_bit_saver_clear` at t+1.
  - `o_core_ready` from t+2.
- Zero-stall frame of N beats:
  - Beats accepted at t+2 … t+N+1.
  - Hard mode: `o_done` at t+N+2.
- Iterations:
  - First `o_iter_start` at the cycle after the last beat.
  - `i_iter_done` at cycle k → next `o_iter_start` at k+1.
- Early stop:
  - Early-stop pulse at cycle k in DECODE → `o_done` at k+1.
  - `o_early_stop` visible at k+1.
- Mode and code outputs change only in the cycle after `i_core_set`.

## Configuration
- Macro: `DECODE_FRAME_CTRL_ITER_LIMIT_EN`.
- Defined: the MAX_ITER termination and `o_max_iter_hit` behave as described above.
- Undefined:
  - DECODE terminates only on early stop or on an `i_core_set` abort.
  - `o_iter_cnt` saturates at 2^ITER_W−1.
  - `o_max_iter_hit` is tied 0.

## Test plan
- Reset, then `i_core_set` with code=0, mode=0 and valid held high:
  - Clear at t+1; 8 syndrome strobes at t+2..t+9.
  - clear_and_wen only at t+2; no llr_mem_wen.
  - `o_done` at t+10.
- code=3, mode=1, with valid deasserted every 3rd cycle:
  - Exactly 128 syndrome_wen and 128 llr_mem_wen.
  - `o_beat_idx` runs 0..127 with no skips.
  - DECODE entered after beat 127.
- code=1 (index 0 → 8 beats), mode=1; bench returns `i_iter_done` 5 cycles after each start; no early stop, ITER_LIMIT_EN defined:
  - 15 iteration starts.
  - `o_max_iter_hit`=1, `o_iter_cnt`=15, then `o_done`.
- Early stop coincident with `i_iter_done` on iteration 15:
  - `o_early_stop`=1, `o_max_iter_hit`=0, `o_done` the next cycle.
- `i_core_set` during beat 40 of a 128-beat load:
  - Strobes stop immediately.
  - Clear at the next cycle; the new frame restarts at beat 0.
  - `o_early_stop` is cleared.
- `i_rst` asserted mid-DECODE: all outputs 0 the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/decode_frame_ctrl.sv
// Frame controller for the decoder core: CLEAR -> LOAD -> DECODE -> DONE per frame.
// Optional macro DECODE_FRAME_CTRL_ITER_LIMIT_EN enables MAX_ITER termination and o_max_iter_hit.
module decode_frame_ctrl #(
  parameter int LEN0     = 8,
  parameter int LEN1     = 32,
  parameter int LEN2     = 128,
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_core_set,
  input  logic              i_core_mode,
  input  logic [1:0]        i_core_code,
  input  logic              i_core_valid,
  output logic              o_core_ready,
  output logic              o_mode,
  output logic [1:0]        o_code,
  output logic [CNT_W-1:0]  o_beat_idx,
  output logic              o_syndrome_clear_and_wen,
  output logic              o_syndrome_wen,
  output logic              o_llr_mem_wen,
  output logic              o_error_bit_saver_clear,
  output logic              o_iter_start,
  input  logic              i_iter_done,
  output logic [ITER_W-1:0] o_iter_cnt,
  input  logic              i_early_stop_pulse,
  output logic              o_early_stop,
  output logic              o_max_iter_hit,
  output logic              o_busy,
  output logic              o_done
);

`ifdef DECODE_FRAME_CTRL_ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DECODE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [1:0]          code_q, code_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                early_q, early_d;
  logic                max_hit_q, max_hit_d;
  logic                iter_start_q, iter_start_d;

  logic [CNT_W-1:0]    last_beat;
  logic [ITER_W-1:0]   iter_inc;
  logic                ready, accept, iter_last;

  always_comb begin
    case (code_q)
      2'd0:    last_beat = CNT_W'(LEN0 - 1);
      2'd1:    last_beat = CNT_W'(LEN1 - 1);
      default: last_beat = CNT_W'(LEN2 - 1);
    endcase
  end

  // A new frame request wins over a beat presented in the same cycle.
  assign ready     = (state_q == S_LOAD) && !i_core_set;
  assign accept    = ready && i_core_valid;
  assign iter_last = (iter_q == ITER_W'(MAX_ITER - 1));
  // Without the limit the counter saturates instead of wrapping.
  assign iter_inc  = (!LIMIT_EN && (iter_q == '1)) ? iter_q : iter_q + ITER_W'(1);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    code_d       = code_q;
    beat_d       = beat_q;
    iter_d       = iter_q;
    early_d      = early_q;
    max_hit_d    = max_hit_q;
    iter_start_d = 1'b0;
    if (i_core_set) begin
      mode_d    = i_core_mode;
      code_d    = (i_core_code == 2'd3) ? 2'd2 : (i_core_code == 2'd2) ? 2'd1 : 2'd0;
      beat_d    = '0;
      iter_d    = '0;
      early_d   = 1'b0;
      max_hit_d = 1'b0;
      state_d   = S_CLEAR;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (i_early_stop_pulse) early_d = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (i_early_stop_pulse) early_d = 1'b1;
          if (accept) begin
            beat_d = beat_q + CNT_W'(1);
            if (beat_q == last_beat) begin
              if (!mode_q || early_q) begin
                state_d = S_DONE;
              end else begin
                state_d      = S_DECODE;
                iter_start_d = 1'b1;
              end
            end
          end
        end
        S_DECODE: begin
          if (i_iter_done) iter_d = iter_inc;
          if (i_early_stop_pulse) begin
            early_d = 1'b1;
            state_d = S_DONE;
          end else if (LIMIT_EN && i_iter_done && iter_last) begin
            max_hit_d = 1'b1;
            state_d   = S_DONE;
          end else if (i_iter_done) begin
            iter_start_d = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      code_q       <= 2'd0;
      beat_q       <= '0;
      iter_q       <= '0;
      early_q      <= 1'b0;
      max_hit_q    <= 1'b0;
      iter_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      code_q       <= code_d;
      beat_q       <= beat_d;
      iter_q       <= iter_d;
      early_q      <= early_d;
      max_hit_q    <= max_hit_d;
      iter_start_q <= iter_start_d;
    end
  end

  assign o_core_ready             = ready;
  assign o_mode                   = mode_q;
  assign o_code                   = code_q;
  assign o_beat_idx               = beat_q;
  assign o_syndrome_wen           = accept;
  assign o_syndrome_clear_and_wen = accept && (beat_q == '0);
  assign o_llr_mem_wen            = accept && mode_q;
  assign o_error_bit_saver_clear  = (state_q == S_CLEAR);
  assign o_iter_start             = iter_start_q;
  assign o_iter_cnt               = iter_q;
  assign o_early_stop             = early_q;
  assign o_max_iter_hit           = max_hit_q;
  assign o_busy                   = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_DECODE);
  assign o_done                   = (state_q == S_DONE);

endmodule

// File: tb/tb_decode_frame_ctrl.sv
// Bench for decode_frame_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_decode_frame_ctrl;
`ifdef DECODE_FRAME_CTRL_ITER_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int P_IDLE = 0, P_CLR = 1, P_LD = 2, P_DEC = 3, P_DN = 4;

  logic clk = 1'b0, rst, set, mode, valid, idone, resp_es, drv_es, esp;
  logic [1:0] code;
  logic ready, o_mode, scw, swen, llr, ebc, istart, o_es, o_mh, busy, done;
  logic [1:0] o_code;
  logic [7:0] beat;
  logic [3:0] icnt;

  assign esp = resp_es | drv_es;
  always #5 clk = ~clk;

  decode_frame_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_core_set(set), .i_core_mode(mode), .i_core_code(code),
    .i_core_valid(valid), .o_core_ready(ready), .o_mode(o_mode), .o_code(o_code),
    .o_beat_idx(beat), .o_syndrome_clear_and_wen(scw), .o_syndrome_wen(swen),
    .o_llr_mem_wen(llr), .o_error_bit_saver_clear(ebc), .o_iter_start(istart),
    .i_iter_done(idone), .o_iter_cnt(icnt), .i_early_stop_pulse(esp), .o_early_stop(o_es),
    .o_max_iter_hit(o_mh), .o_busy(busy), .o_done(done));

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 0;
  // model state
  int m_ph, m_mode, m_code, m_beat, m_iter, m_es, m_mh, m_launch;
  // observed statistics
  int n_swen, n_scw, n_llr, n_start, n_skip, exp_b, last_b, clr_cyc, done_cyc, es_cyc, n_done;
  bit done_seen;
  int es_on_done = 0, cd = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s act=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int len_of(input int c);
    return (c == 0) ? 8 : (c == 1) ? 32 : 128;
  endfunction

  task automatic model_step();
    bit acc, last, old_es;
    int old_iter;
    acc = (m_ph == P_LD) && valid && !set;
    old_es = m_es[0];
    old_iter = m_iter;
    m_launch = 0;
    if (rst) begin
      m_ph = P_IDLE; m_mode = 0; m_code = 0; m_beat = 0; m_iter = 0; m_es = 0; m_mh = 0;
    end else if (set) begin
      m_mode = int'(mode); m_code = (code <= 2'd1) ? 0 : int'(code) - 1;
      m_beat = 0; m_iter = 0; m_es = 0; m_mh = 0; m_ph = P_CLR;
    end else if (m_ph == P_CLR) begin
      if (esp) m_es = 1;
      m_ph = P_LD;
    end else if (m_ph == P_LD) begin
      last = acc && (m_beat == len_of(m_code) - 1);
      if (acc) m_beat++;
      if (last && (m_mode == 0 || old_es)) m_ph = P_DN;
      else if (last) begin m_ph = P_DEC; m_launch = 1; end
      if (esp) m_es = 1;
    end else if (m_ph == P_DEC) begin
      if (idone) m_iter = (!LIM && old_iter == 15) ? 15 : old_iter + 1;
      if (esp) begin m_es = 1; m_ph = P_DN; end
      else if (LIM && idone && old_iter == 14) begin m_mh = 1; m_ph = P_DN; end
      else if (idone) m_launch = 1;
    end else if (m_ph == P_DN) m_ph = P_IDLE;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // per-cycle comparison against the model, plus statistics for directed checks
  initial forever begin
    bit er, acc;
    @(negedge clk);
    if (chk_en) begin
      er  = (m_ph == P_LD) && !set;
      acc = er && valid;
      chk("ready", int'(ready), int'(er));
      chk("swen", int'(swen), int'(acc));
      chk("scw", int'(scw), int'(acc && m_beat == 0));
      chk("llr", int'(llr), int'(acc && m_mode == 1));
      chk("ebc", int'(ebc), int'(m_ph == P_CLR));
      chk("busy", int'(busy), int'(m_ph >= P_CLR && m_ph <= P_DEC));
      chk("done", int'(done), int'(m_ph == P_DN));
      chk("iter_start", int'(istart), m_launch);
      chk("mode", int'(o_mode), m_mode);
      chk("code", int'(o_code), m_code);
      chk("beat_idx", int'(beat), m_beat);
      chk("iter_cnt", int'(icnt), m_iter);
      chk("early_stop", int'(o_es), m_es);
      chk("max_iter_hit", int'(o_mh), m_mh);
    end
    if (ebc) begin exp_b = 0; clr_cyc = cyc; end
    if (swen) begin
      if (int'(beat) != exp_b) n_skip++;
      exp_b++; last_b = int'(beat); n_swen++;
    end
    if (scw) n_scw++;
    if (llr) n_llr++;
    if (istart) n_start++;
    if (done) begin done_seen = 1; done_cyc = cyc; end
  end

  // iteration engine stand-in: iter_done 5 cycles after each start
  initial begin
    idone = 0; resp_es = 0;
    forever begin
      @(posedge clk); #1;
      idone = 0; resp_es = 0;
      if (ebc) begin cd = 0; n_done = 0; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          idone = 1; n_done++;
          if (n_done == es_on_done) begin resp_es = 1; es_cyc = cyc; end
        end
      end
      if (istart) cd = 5;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clr_stats();
    n_swen = 0; n_scw = 0; n_llr = 0; n_start = 0; n_skip = 0; last_b = -1;
    done_seen = 0; done_cyc = -1; clr_cyc = -1;
  endtask

  task automatic start(input bit md, input logic [1:0] cd_in);
    set = 1; mode = md; code = cd_in; tick(); set = 0; clr_stats();
  endtask

  task automatic wait_done(input int budget, input string nm);
    int i = 0;
    while (!done_seen && i < budget) begin tick(); i++; end
    if (!done_seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst = 1; set = 0; mode = 0; code = 0; valid = 0; drv_es = 0;
    clr_stats();
    tick(); chk_en = 1; tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_iter_cnt", int'(icnt), 0);
    rst = 0; tick();

    // hard frame, code 0, valid held high
    valid = 1; start(0, 2'd0);
    wait_done(40, "t1");
    chk("t1_swen_cnt", n_swen, 8);
    chk("t1_scw_cnt", n_scw, 1);
    chk("t1_llr_cnt", n_llr, 0);
    chk("t1_done_lat", done_cyc - clr_cyc, 9);
    tick();

    // soft frame, code 3, valid low every third cycle
    start(1, 2'd3);
    for (int i = 0; i < 400 && n_start == 0; i++) begin valid = (i % 3 != 2); tick(); end
    valid = 1;
    chk("t2_swen_cnt", n_swen, 128);
    chk("t2_llr_cnt", n_llr, 128);
    chk("t2_beat_skip", n_skip, 0);
    chk("t2_last_beat", last_b, 127);
    chk("t2_decode_entered", n_start, 1);

    // code 1 -> index 0, iterate to the limit (or early stop past saturation)
    es_on_done = LIM ? 0 : 18;
    start(1, 2'd1);
    wait_done(400, "t3");
    tick();
    chk("t3_starts", n_start, LIM ? 15 : 18);
    chk("t3_iter_cnt", int'(icnt), 15);
    chk("t3_max_hit", int'(o_mh), LIM ? 1 : 0);
    chk("t3_idle_code", int'(o_code), 0);

    // early stop coincident with the 15th iter_done
    es_on_done = 15;
    start(1, 2'd1);
    wait_done(400, "t4");
    chk("t4_done_after_es", done_cyc - es_cyc, 1);
    tick();
    chk("t4_early", int'(o_es), 1);
    chk("t4_max_hit", int'(o_mh), 0);
    chk("t4_iter_cnt", int'(icnt), 15);
    es_on_done = 0;

    // abort during beat 40 of a 128-beat load
    start(1, 2'd3);
    for (int i = 0; i < 200; i++) begin
      drv_es = ready && (beat == 8'd5);
      if (ready && beat == 8'd40) break;
      tick();
    end
    drv_es = 0;
    chk("t5_es_before", int'(o_es), 1);
    set = 1; mode = 0; code = 2'd0; #1;
    chk("t5_swen_in_set", int'(swen), 0);
    tick(); set = 0; clr_stats();
    chk("t5_clear", int'(ebc), 1);
    chk("t5_es_cleared", int'(o_es), 0);
    chk("t5_beat0", int'(beat), 0);
    wait_done(40, "t5");
    chk("t5_swen_cnt", n_swen, 8);
    chk("t5_scw_cnt", n_scw, 1);
    tick();

    // reset mid-decode
    start(1, 2'd1);
    for (int i = 0; i < 100 && n_start < 2; i++) tick();
    chk("t6_in_decode", int'(busy), 1);
    rst = 1; tick();
    chk("t6_busy", int'(busy), 0);
    chk("t6_mode", int'(o_mode), 0);
    chk("t6_iter_cnt", int'(icnt), 0);
    chk("t6_beat", int'(beat), 0);
    chk("t6_iter_start", int'(istart), 0);
    chk("t6_ready", int'(ready), 0);
    rst = 0; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
